// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the instruction-memory responder.
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD_DFLT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response plus the side load port of the instruction memory.
interface imem_responder_if import cpu_pkg::*; #(
    parameter int DEPTH_LOG2 = 10
) ();
    logic                  Memread;
    logic [31:0]           Addr;
    logic [INSTR_W-1:0]    Mem;
    logic                  MemReady;
    logic                  Fault;
    logic                  LoadEn;
    logic [DEPTH_LOG2-1:0] LoadAddr;
    logic [INSTR_W-1:0]    LoadData;

    modport master (
        output Memread, Addr, LoadEn, LoadAddr, LoadData,
        input  Mem, MemReady, Fault
    );

    modport slave (
        input  Memread, Addr, LoadEn, LoadAddr, LoadData,
        output Mem, MemReady, Fault
    );
endinterface

// File: rtl/imem_array.sv
// Word array: synchronous write, asynchronous read. A read sampled on the same
// edge as a write to that word therefore sees the old contents.
module imem_array import cpu_pkg::*; #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [INSTR_W-1:0]    wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [INSTR_W-1:0]    rdata
);
    logic [INSTR_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: level-held fetch, fixed latency, fault on
// misaligned/out-of-range addresses, and a free-running load port.
module imem_responder import cpu_pkg::*; #(
    parameter int                 DEPTH_LOG2 = 10,
    parameter int                 LATENCY    = 1,
    parameter logic [31:0]        BASE       = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_WORD   = NOP_WORD_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    imem_responder_if.slave   bus
);
    localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [INSTR_W-1:0] mem_q, mem_d;
    logic               rdy_q, rdy_d;
    logic               fault_q, fault_d;

    logic [31:0]        sel_addr;
    logic [31:0]        offset;
    logic               bad;
    logic [INSTR_W-1:0] rd_data;

    // In IDLE the live address is used so LATENCY=1 can respond on the capture edge.
    always_comb begin
        sel_addr = (state_q == IDLE) ? bus.Addr : addr_q;
        offset   = sel_addr - BASE;
        bad      = (sel_addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
    end

    imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (bus.LoadEn),
        .waddr (bus.LoadAddr),
        .wdata (bus.LoadData),
        .raddr (offset[DEPTH_LOG2+1:2]),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mem_d   = mem_q;
        rdy_d   = rdy_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Memread) begin
                    addr_d = bus.Addr;
                    if (LATENCY == 1) begin
                        mem_d   = bad ? NOP_WORD : rd_data;
                        fault_d = bad;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!bus.Memread) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        mem_d   = bad ? NOP_WORD : rd_data;
                        fault_d = bad;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.Memread) begin
                    rdy_d   = 1'b0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            mem_q   <= '0;
            rdy_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mem_q   <= mem_d;
            rdy_q   <= rdy_d;
            fault_q <= fault_d;
        end
    end

    assign bus.Mem      = mem_q;
    assign bus.MemReady = rdy_q;
    assign bus.Fault    = fault_q;
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=1 and a LATENCY=4 instance, scoreboarded.
module tb_imem_responder;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] mem;
        logic        fault;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_responder_if #(.DEPTH_LOG2(10)) if1 ();
    imem_responder_if #(.DEPTH_LOG2(10)) if4 ();

    imem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE(32'h0), .NOP_WORD(32'h0000_0000))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    imem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .BASE(32'h0), .NOP_WORD(32'h0000_0013))
        u4 (.clk(clk), .rst(rst), .bus(if4));

    int total = 0;
    int bad = 0;
    rsp_t sb[$];
    logic [31:0] model [2][1024];
    logic [31:0] nop [2] = '{32'h0000_0000, 32'h0000_0013};

    function automatic rsp_t exp_rsp(input int w, input logic [31:0] a);
        rsp_t r;
        if (a[1:0] != 2'b00 || a >= 32'h0000_1000) r = '{mem: nop[w], fault: 1'b1};
        else r = '{mem: model[w][a[11:2]], fault: 1'b0};
        return r;
    endfunction

    task automatic set_req(input int w, input logic rd, input logic [31:0] a);
        if (w == 0) begin if1.Memread = rd; if1.Addr = a; end
        else begin if4.Memread = rd; if4.Addr = a; end
    endtask

    task automatic set_load(input int w, input logic en, input logic [9:0] idx, input logic [31:0] d);
        if (w == 0) begin if1.LoadEn = en; if1.LoadAddr = idx; if1.LoadData = d; end
        else begin if4.LoadEn = en; if4.LoadAddr = idx; if4.LoadData = d; end
    endtask

    task automatic get_rsp(input int w, output logic r, output logic [31:0] m, output logic f);
        if (w == 0) begin r = if1.MemReady; m = if1.Mem; f = if1.Fault; end
        else begin r = if4.MemReady; m = if4.Mem; f = if4.Fault; end
    endtask

    task automatic load(input int w, input logic [9:0] idx, input logic [31:0] d);
        @(negedge clk);
        set_load(w, 1'b1, idx, d);
        @(negedge clk);
        set_load(w, 1'b0, '0, '0);
        model[w][idx] = d;
    endtask

    // Full fetch: capture, wait for MemReady (bounded), check latency, data,
    // hold in DONE, then release and check the return to IDLE.
    task automatic fetch(input int w, input logic [31:0] a, input bit chg, input bit collide);
        int lat = (w == 0) ? 1 : 4;
        int n = 0;
        rsp_t e;
        logic r, f;
        logic [31:0] m;
        @(negedge clk);
        set_req(w, 1'b1, a);
        sb.push_back(exp_rsp(w, a));
        if (collide) begin
            set_load(w, 1'b1, a[11:2], 32'hFFFF_FFFF);
            model[w][a[11:2]] = 32'hFFFF_FFFF;
        end
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) set_load(w, 1'b0, '0, '0);
            if (chg && n == 1) set_req(w, 1'b1, 32'h0000_0010);
            get_rsp(w, r, m, f);
        end while (!r && n < 20);
        total++;
        if (r !== 1'b1) begin bad++; $display("FAIL ready_timeout dut%0d addr=%h got=%b want=1", w, a, r); end
        total++;
        if (n != lat) begin bad++; $display("FAIL latency dut%0d addr=%h got=%0d want=%0d", w, a, n, lat); end
        e = sb.pop_front();
        total++;
        if (m !== e.mem) begin bad++; $display("FAIL mem dut%0d addr=%h got=%h want=%h", w, a, m, e.mem); end
        total++;
        if (f !== e.fault) begin bad++; $display("FAIL fault dut%0d addr=%h got=%b want=%b", w, a, f, e.fault); end
        @(posedge clk); #1;
        get_rsp(w, r, m, f);
        total++;
        if (r !== 1'b1 || m !== e.mem || f !== e.fault) begin
            bad++; $display("FAIL done_hold dut%0d got=%b/%h/%b want=1/%h/%b", w, r, m, f, e.mem, e.fault);
        end
        @(negedge clk);
        set_req(w, 1'b0, a);
        @(posedge clk); #1;
        get_rsp(w, r, m, f);
        total++;
        if (r !== 1'b0 || f !== 1'b0 || m !== e.mem) begin
            bad++; $display("FAIL release dut%0d got=%b/%h/%b want=0/%h/0", w, r, m, f, e.mem);
        end
    endtask

    task automatic test_reset();
        logic r, f;
        logic [31:0] m;
        set_req(0, 1'b0, '0); set_req(1, 1'b0, '0);
        set_load(0, 1'b0, '0, '0); set_load(1, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            get_rsp(w, r, m, f);
            total++;
            if (r !== 1'b0 || f !== 1'b0 || m !== 32'h0) begin
                bad++; $display("FAIL reset_state dut%0d got=%b/%h/%b want=0/0/0", w, r, m, f);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        fetch(0, 32'h0000_000C, 0, 0);
        fetch(0, 32'h0000_0FFC, 0, 0);
    endtask

    task automatic test_latency();
        fetch(1, 32'h0000_0000, 1, 0);
        fetch(1, 32'h0000_000C, 0, 0);
    endtask

    task automatic test_fault();
        fetch(0, 32'h0000_0006, 0, 0);
        fetch(0, 32'h0000_1000, 0, 0);
        fetch(1, 32'h0000_1000, 0, 0);
        fetch(1, 32'h0000_0011, 0, 0);
    endtask

    task automatic test_abort();
        logic r, f;
        logic [31:0] m;
        int seen = 0;
        @(negedge clk);
        set_req(1, 1'b1, 32'h0000_000C);
        repeat (2) begin
            @(posedge clk); #1;
            get_rsp(1, r, m, f);
            if (r) seen++;
        end
        @(negedge clk);
        set_req(1, 1'b0, 32'h0000_000C);
        repeat (4) begin
            @(posedge clk); #1;
            get_rsp(1, r, m, f);
            if (r) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort_no_ready got=%0d want=0", seen); end
        fetch(1, 32'h0000_000C, 0, 0);
    endtask

    task automatic test_collision();
        fetch(0, 32'h0000_000C, 0, 1);
        fetch(0, 32'h0000_000C, 0, 0);
    endtask

    task automatic test_reset_in_done();
        logic r, f;
        logic [31:0] m;
        int n = 0;
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_000C);
        do begin
            @(posedge clk); #1;
            n++;
            get_rsp(0, r, m, f);
        end while (!r && n < 20);
        total++;
        if (r !== 1'b1 || m !== model[0][3]) begin
            bad++; $display("FAIL pre_reset_done got=%b/%h want=1/%h", r, m, model[0][3]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        get_rsp(0, r, m, f);
        total++;
        if (r !== 1'b0 || f !== 1'b0 || m !== 32'h0) begin
            bad++; $display("FAIL reset_in_done got=%b/%h/%b want=0/0/0", r, m, f);
        end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b0, '0);
        fetch(0, 32'h0000_000C, 0, 0);
    endtask

    task automatic test_back_to_back();
        fetch(1, 32'h0000_0010, 0, 0);
        fetch(1, 32'h0000_0000, 0, 0);
        fetch(0, 32'h0000_0FFC, 0, 0);
        fetch(0, 32'h0000_000C, 0, 0);
    endtask

    initial begin
        test_reset();
        load(0, 10'd3, 32'h2008_0005);
        load(1, 10'd3, 32'h2008_0005);
        load(0, 10'd1023, 32'hA5A5_1023);
        load(1, 10'd0, 32'h1111_0000);
        load(1, 10'd4, 32'h4444_0000);
        test_basic();
        test_latency();
        test_fault();
        test_abort();
        test_collision();
        test_reset_in_done();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the CPU fetch stage. It accepts a level-held `Memread` request with a byte address `Addr` and returns the 32-bit instruction word on `Mem`, flagged by `MemReady`, after a configurable latency. A side load port lets the debug/boot path write program words into the array.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 1: cycles from request capture to `MemReady`; legal range 1..15.
- `BASE`, 32'h0000_0000: byte address of word 0.
- `NOP_WORD`, 32'h0000_0000: value returned on fault.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Memread`  in  1  fetch request; held high until `MemReady` is seen.
- `Addr`  in  32  byte address of the requested instruction.
- `Mem`  out  32  instruction word; valid while `MemReady`=1.
- `MemReady`  out  1  response valid.
- `Fault`  out  1  response is `NOP_WORD` because of a misaligned or out-of-range address; valid with `MemReady`.
- `LoadEn`  in  1  write strobe for the load port.
- `LoadAddr`  in  DEPTH_LOG2  word index to write.
- `LoadData`  in  32  word to write.

## Operation
- Reset values: state IDLE, `Mem`=0, `MemReady`=0, `Fault`=0, latency counter 0. Array contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**, `Memread`=1:
  - Latch `Addr` and compute `offset = Addr - BASE` (32-bit, wraps).
  - If `LATENCY`=1, go straight to DONE, loading `Mem`, `Fault` and `MemReady`=1 on this edge.
  - Otherwise go to BUSY with counter = `LATENCY`-1.
- **BUSY**:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 1, load the outputs and go to DONE.
  - `Addr` changes while BUSY are ignored; the latched address is used.
- **DONE**:
  - Hold `Mem`, `Fault` and `MemReady`=1 while `Memread`=1.
  - When `Memread`=0, return to IDLE and clear `MemReady` and `Fault` on that edge. `Mem` keeps its last value.
- Abort: `Memread`=0 in BUSY returns the FSM to IDLE with no response.
- Fault rules, checked on the latched address:
  - Misaligned: `Addr[1:0]`≠0.
  - Out of range: unsigned `offset` ≥ 4·2^DEPTH_LOG2.
  - On fault, `Mem`=`NOP_WORD` and `Fault`=1.
  - Otherwise `Mem` = array[`offset[DEPTH_LOG2+1:2]`] and `Fault`=0.
- Load port:
  - `LoadEn`=1 writes `LoadData` to `LoadAddr` on the edge, in any state.
  - A write and a response load to the same word on the same edge return the OLD word (read-before-write).
- Reset asserted in any state aborts the operation and forces all reset values on that edge.

## Timing
- Request capture happens on the first edge where `Memread`=1 in IDLE (edge E0).
- `MemReady` rises after edge E0+`LATENCY`-1; with the default `LATENCY`=1 it is visible in the cycle right after E0.
- Minimum spacing between back-to-back fetches: `Memread` must drop for at least one edge (the DONE→IDLE edge). The next request is captured at the earliest on the following edge.
- The load port is always one-cycle write, with no stall and no ready signal.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - the `NOP_WORD` default;
  - the `INSTR_W`=32 constant.
- One sub-module, `imem_array`: a 2^DEPTH_LOG2×32 array with a synchronous write port and a read port, read-before-write on collision.
- The top level holds the FSM, latency counter, address latch and fault logic.

## Test plan
- Reset, then load word 3 = 32'h2008_0005; fetch `Addr`=32'h0000_000C with `LATENCY`=1 → `MemReady`=1 one edge after capture, `Mem`=32'h2008_0005, `Fault`=0.
- `LATENCY`=4, fetch `Addr`=0 holding `Memread` → `MemReady` rises after edge E0+3. Changing `Addr` to 32'h10 mid-BUSY has no effect on `Mem`.
- Fetch `Addr`=32'h0000_0006 → `Fault`=1, `Mem`=`NOP_WORD`. With `DEPTH_LOG2`=10, fetch `Addr`=32'h0000_1000 → `Fault`=1.
- Drop `Memread` during BUSY → no `MemReady`, FSM back in IDLE. A new fetch of word 3 two edges later returns 32'h2008_0005.
- On the completion edge, `LoadEn` writes 32'hFFFF_FFFF to the same word → `Mem` shows the old value. A refetch returns 32'hFFFF_FFFF.
- Assert `rst` while in DONE → next cycle `MemReady`=0, `Fault`=0, `Mem`=0, and array contents are preserved.
